// File: rtl/mux2_1_arbiter.sv
// Round-robin arbiter sharing one mux2_1 between two valid/ready requesters, bursts capped at BURST_MAX.
// Grant one cycle after request, registered output one cycle after accept; a stalled output holds both readies low.

module mux2_1 #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_in0,
   input  logic [WIDTH-1:0] i_in1,
   input  logic             i_sel,
   output logic [WIDTH-1:0] o_out
);
   assign o_out = i_sel ? i_in1 : i_in0;
endmodule

module mux2_1_arbiter #(
   parameter int WIDTH     = 4,
   parameter int BURST_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             sel
);
   localparam int             CW       = $clog2(BURST_MAX) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(BURST_MAX - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   state_t           w_other_state;
   logic [CW-1:0]    r_beat_cnt;
   logic [CW-1:0]    w_beat_cnt_nxt;
   logic             r_last_grant;
   logic             w_last_grant_nxt;
   logic             r_sel;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [WIDTH-1:0] w_mux_out;
   logic             w_out_free;
   logic             w_acc0;
   logic             w_acc1;
   logic             w_own_valid;
   logic             w_own_acc;
   logic             w_other_valid;
   logic             w_done;

   assign w_out_free = !r_out_valid || out_ready;
   assign req0_ready = (r_state == GRANT0) && w_out_free;
   assign req1_ready = (r_state == GRANT1) && w_out_free;
   assign w_acc0     = req0_valid && req0_ready;
   assign w_acc1     = req1_valid && req1_ready;

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign sel        = r_sel;

   mux2_1 #(.WIDTH(WIDTH)) u_mux (
      .i_in0 (req0_data),
      .i_in1 (req1_data),
      .i_sel (r_sel),
      .o_out (w_mux_out)
   );

   always_comb begin
      w_own_valid   = req0_valid;
      w_own_acc     = w_acc0;
      w_other_valid = req1_valid;
      w_other_state = GRANT1;
      if (r_state == GRANT1) begin
         w_own_valid   = req1_valid;
         w_own_acc     = w_acc1;
         w_other_valid = req0_valid;
         w_other_state = GRANT0;
      end
   end

   // A burst ends on a valid drop or on its final counted beat.
   assign w_done = !w_own_valid || (w_own_acc && (r_beat_cnt == CNT_LAST));

   always_comb begin
      w_state_nxt      = r_state;
      w_beat_cnt_nxt   = r_beat_cnt;
      w_last_grant_nxt = r_last_grant;
      case (r_state)
         GRANT0, GRANT1: begin
            if (w_own_acc) begin
               w_beat_cnt_nxt = r_beat_cnt + CW'(1);
            end
            if (w_done) begin
               if (w_other_valid) begin
                  w_state_nxt      = w_other_state;
                  w_last_grant_nxt = (w_other_state == GRANT1);
                  w_beat_cnt_nxt   = '0;
               end else if (w_own_valid) begin
                  w_beat_cnt_nxt   = '0;
               end else begin
                  w_state_nxt      = IDLE;
               end
            end
         end
         default: begin
            if (req0_valid && (!req1_valid || r_last_grant)) begin
               w_state_nxt      = GRANT0;
               w_last_grant_nxt = 1'b0;
               w_beat_cnt_nxt   = '0;
            end else if (req1_valid) begin
               w_state_nxt      = GRANT1;
               w_last_grant_nxt = 1'b1;
               w_beat_cnt_nxt   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_beat_cnt   <= '0;
         r_last_grant <= 1'b1;
         r_sel        <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_beat_cnt   <= w_beat_cnt_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_sel        <= (w_state_nxt == GRANT1);
         if (w_acc0 || w_acc1) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux_out;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_mux2_1_arbiter.sv
// Bench for mux2_1_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.

module tb_mux2_1_arbiter;
   localparam int W  = 4;
   localparam int BM = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid, req1_valid, out_ready;
   logic [W-1:0] req0_data, req1_data, out_data;
   logic         req0_ready, req1_ready, out_valid, sel;

   always #5 clk = ~clk;

   mux2_1_arbiter #(.WIDTH(W), .BURST_MAX(BM)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .sel        (sel)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: current owner (-1 none), beats taken in this burst, last winner, output slot.
   int           m_gnt, m_cnt, m_last;
   bit           m_ov;
   logic [W-1:0] m_od;

   // Producer side: pending beat per requester, its data, fixed data (-1 random), beats left to offer (-1 unlimited).
   bit           pend [2];
   logic [W-1:0] pdat [2];
   int           fixd [2];
   int           budget [2];
   int           dut_acc1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_gnt  = -1;
      m_cnt  = 0;
      m_last = 1;
      m_ov   = 0;
      m_od   = '0;
   endtask

   // Entered and left at a falling edge.
   task automatic cycle(input int p0, input int p1, input int prdy);
      bit v [2];
      bit r [2];
      bit a [2];
      int pct [2];
      int g, n, o;
      bit full, drop;
      pct[0] = p0;
      pct[1] = p1;
      for (int k = 0; k < 2; k++) begin
         if (!pend[k] && budget[k] != 0 && int'($urandom_range(99)) < pct[k]) begin
            pend[k] = 1;
            pdat[k] = (fixd[k] >= 0) ? W'(fixd[k]) : W'($urandom);
            if (budget[k] > 0) budget[k]--;
         end
      end
      req0_valid = pend[0];
      req0_data  = pdat[0];
      req1_valid = pend[1];
      req1_data  = pdat[1];
      out_ready  = (int'($urandom_range(99)) < prdy);
      #1;
      for (int k = 0; k < 2; k++) begin
         v[k] = pend[k];
         r[k] = (m_gnt == k) && (!m_ov || out_ready);
         a[k] = v[k] && r[k];
      end
      check("req0_ready", req0_ready, r[0]);
      check("req1_ready", req1_ready, r[1]);
      check("sel",        sel,        m_gnt == 1);
      check("out_valid",  out_valid,  m_ov);
      check("out_data",   out_data,   m_od);
      if (req1_valid && req1_ready) dut_acc1++;

      if (a[0] || a[1]) begin
         m_ov = 1;
         m_od = a[0] ? pdat[0] : pdat[1];
      end else if (out_ready) begin
         m_ov = 0;
      end
      if (m_gnt < 0) begin
         g = -1;
         if (v[0] && v[1]) g = 1 - m_last;
         else if (v[0])    g = 0;
         else if (v[1])    g = 1;
         if (g >= 0) begin
            m_gnt  = g;
            m_last = g;
            m_cnt  = 0;
         end
      end else begin
         n = m_gnt;
         o = 1 - n;
         if (a[n]) m_cnt++;
         full = a[n] && (m_cnt == BM);
         drop = !v[n];
         if (full || drop) begin
            if (v[o]) begin
               m_gnt  = o;
               m_last = o;
               m_cnt  = 0;
            end else if (full) begin
               m_cnt  = 0;
            end else begin
               m_gnt  = -1;
            end
         end
      end
      for (int k = 0; k < 2; k++) if (a[k]) pend[k] = 0;
      @(negedge clk);
   endtask

   // Asserts reset between edges and checks the outputs clear immediately.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid",  out_valid,  1'b0);
      check("rst_out_data",   out_data,   '0);
      check("rst_sel",        sel,        1'b0);
      check("rst_req0_ready", req0_ready, 1'b0);
      check("rst_req1_ready", req1_ready, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int k;
      req0_valid = 0; req1_valid = 0; out_ready = 0;
      req0_data  = '0; req1_data = '0;
      model_reset();
      pend[0] = 0; pend[1] = 0;
      pdat[0] = '0; pdat[1] = '0;
      fixd[0] = 6; fixd[1] = 9;
      budget[0] = 0; budget[1] = 0;
      dut_acc1 = 0;
      @(negedge clk);
      rst = 1'b0;

      // Single req0 beat: grant next cycle, output the cycle after.
      budget[0] = 1;
      repeat (5) cycle(100, 0, 100);

      do_reset();

      // Continuous contention: 4-beat bursts alternating, requester 0 first.
      budget[0] = -1; budget[1] = -1;
      repeat (24) cycle(100, 100, 100);
      do_reset();

      // Backpressure during a GRANT1 stream.
      budget[0] = 0;
      repeat (3) cycle(0, 100, 100);
      repeat (3) cycle(0, 100, 0);
      repeat (4) cycle(0, 100, 100);
      budget[1] = 0;
      repeat (4) cycle(0, 0, 100);

      // Lone requester 1 with ten beats: no burst cap gaps.
      budget[1] = 10;
      dut_acc1  = 0;
      repeat (16) cycle(0, 100, 100);
      check("t5_beats", dut_acc1, 10);

      // Reset two beats into a GRANT1 burst, then contention.
      budget[1] = -1;
      dut_acc1  = 0;
      k = 0;
      while (dut_acc1 < 2 && k < 10) begin
         cycle(0, 100, 100);
         k++;
      end
      check("t6_two_beats", dut_acc1, 2);
      do_reset();
      budget[0] = -1;
      repeat (12) cycle(100, 100, 100);

      // Randomized traffic in segments of varying intensity.
      fixd[0] = -1; fixd[1] = -1;
      for (int s = 0; s < 16; s++) begin
         int p0, p1, pr;
         p0 = int'($urandom_range(100));
         p1 = int'($urandom_range(100));
         pr = int'($urandom_range(100, 20));
         repeat (100) cycle(p0, p1, pr);
         if (s == 8) do_reset();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mux2_1_arbiter.md
Name: mux2_1_arbiter

Overview:
- Round-robin arbiter that shares one mux2_1 datapath between two streaming requesters, each with a valid/ready handshake.
- It drives the mux select and registers the selected data into a single output stage with a valid/ready handshake toward the consumer.
- Bursts are bounded by BURST_MAX so that one requester cannot starve the other.
- Instantiates mux2_1 internally. Sits between two producers and one shared downstream consumer.

Parameters:
- WIDTH, 4, data width of each requester and of the output; matches the mux2_1 bus width.
- BURST_MAX, 4, maximum consecutive accepted beats per grant while the other requester is waiting. Must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has data.
- req0_data  input  WIDTH  requester 0 data; drives mux in0.
- req0_ready  output  1  requester 0 beat accepted this cycle when req0_valid is also high.
- req1_valid  input  1  requester 1 has data.
- req1_data  input  WIDTH  requester 1 data; drives mux in1.
- req1_ready  output  1  requester 1 beat accepted this cycle when req1_valid is also high.
- out_valid  output  1  out_data holds a beat.
- out_data  output  WIDTH  registered mux output.
- out_ready  input  1  consumer accepts the beat.
- sel  output  1  registered mux select: 0 = requester 0, 1 = requester 1.

Behaviour:
- Reset (async, immediate):
  - out_valid=0, out_data=0, sel=0, req0_ready=0, req1_ready=0.
  - state=IDLE, beat_cnt=0.
  - last_grant=1, so requester 0 wins the first tie.
- States: IDLE, GRANT0, GRANT1. sel = 1 only in GRANT1 (registered with state).
- Readiness (combinational): reqN_ready = (state==GRANTN) && (!out_valid || out_ready).
- Accept: accN = reqN_valid && reqN_ready.
  - On accept, out_data <= mux output (reqN_data) and out_valid <= 1.
  - Otherwise, if out_ready is high, out_valid <= 0.
  - While out_valid && !out_ready, out_data and out_valid hold.
- Requester rule: reqN_data must stay stable and reqN_valid must stay high until accepted. The arbiter treats a valid drop as end of burst.
- IDLE:
  - Neither valid: stay in IDLE.
  - One valid: go to that requester's GRANT.
  - Both valid: go to GRANT of the requester != last_grant.
  - On entry to any GRANT: last_grant updated, beat_cnt=0.
- GRANTn, end of cycle:
  - beat_cnt increments on accN.
  - done = !reqn_valid || (accN && beat_cnt==BURST_MAX-1).
  - If done and the other requester is valid: switch to GRANTother, beat_cnt=0.
  - If done by count and the other is not valid: stay, beat_cnt=0.
  - If done by valid drop and the other is not valid: go to IDLE.
- Latency:
  - Request in IDLE at cycle N: grant at N+1 (ready high, if the output is free).
  - out_valid with that data at N+2.
  - Grant switchover after a final beat has zero bubble: the new requester is ready in the next cycle.
- BURST_MAX=1: strict alternation under contention.
- beat_cnt width: clog2(BURST_MAX)+1; never exceeds BURST_MAX-1.
- Backpressure: a stalled output keeps both readies low. State does not change while no beat is accepted, except for a valid drop.
- Reset mid-burst: the in-flight output beat is discarded. The requester must re-present any unaccepted beat.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> out_valid=0, out_data=0000, sel=0, both readies 0 immediately.
2. req0 only, data 0110, out_ready=1, valid at cycle 0:
   - req0_ready=1 at cycle 1.
   - out_valid=1 with out_data=0110 at cycle 2, sel=0.
3. Both valid continuously, BURST_MAX=4, req0=0110, req1=1001, out_ready=1:
   - out_data shows 4x0110, then 4x1001, repeating, with no bubble cycles.
   - sel toggles every 4 beats; the first burst is requester 0.
4. Backpressure: during a GRANT1 stream, hold out_ready=0 for 3 cycles:
   - out_valid stays 1 and out_data stays 1001.
   - req1_ready=0 for those cycles, and beat_cnt is unchanged.
5. req1 only, valid for 10 beats, BURST_MAX=4 -> 10 consecutive beats accepted, sel=1 throughout, no gaps.
6. Assert rst after 2 beats of a GRANT1 burst, then drive both valid -> out_valid=0 at once, then requester 0 granted first (sel=0).
